// File: rtl/idex_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle bit layout and bubble value.
package idex_pkg;

    localparam int unsigned CTRL_W = 8;

    localparam int unsigned CTRL_JUMP   = 7;
    localparam int unsigned CTRL_REGW   = 6;
    localparam int unsigned CTRL_MEMREG = 5;
    localparam int unsigned CTRL_MEMW   = 4;
    localparam int unsigned CTRL_MEMR   = 3;
    localparam int unsigned CTRL_BRANCH = 2;
    localparam int unsigned CTRL_ALUSRC = 1;
    localparam int unsigned CTRL_REGDST = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 8'h00;

    // An invalid slot must never carry live control bits into EX.
    function automatic logic [CTRL_W-1:0] ctrl_gate(input logic valid,
                                                    input logic [CTRL_W-1:0] ctrl);
        return valid ? ctrl : CTRL_NOP;
    endfunction

endpackage

// File: rtl/idex_pipe_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline register with flush > stall > load priority.
// Define IDEX_PERF_EN to add stall/bubble performance counters and their ports.
module idex_pipe_stage
    import idex_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_stall,
    input  logic               in_flush,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [ALUOP_W-1:0] in_aluop,
    input  logic [DATA_W-1:0]  in_add,
    input  logic [DATA_W-1:0]  in_dr1,
    input  logic [DATA_W-1:0]  in_dr2,
    input  logic [DATA_W-1:0]  in_signe,
    input  logic [DATA_W-1:0]  in_jaddr,
    input  logic [REG_W-1:0]   in_ins1,
    input  logic [REG_W-1:0]   in_ins2,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic [DATA_W-1:0]  out_add,
    output logic [DATA_W-1:0]  out_dr1,
    output logic [DATA_W-1:0]  out_dr2,
    output logic [DATA_W-1:0]  out_signe,
    output logic [DATA_W-1:0]  out_jaddr,
    output logic [REG_W-1:0]   out_ins1,
    output logic [REG_W-1:0]   out_ins2
`ifdef IDEX_PERF_EN
    ,
    input  logic               in_cnt_clr,
    output logic [CNT_W-1:0]   out_stall_cnt,
    output logic [CNT_W-1:0]   out_bubble_cnt
`endif
);

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be nonzero");
    end

    logic do_load;
    assign do_load = !in_flush && !in_stall;

    // Valid and control: flush inserts a bubble, stall holds, load gates ctrl by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_NOP;
        end else if (in_flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_NOP;
        end else if (!in_stall) begin
            out_valid <= in_valid;
            out_ctrl  <= ctrl_gate(in_valid, in_ctrl);
        end
    end

    // Data and specifier fields only move on a load; a bubble leaves them stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_aluop <= '0;
            out_add   <= '0;
            out_dr1   <= '0;
            out_dr2   <= '0;
            out_signe <= '0;
            out_jaddr <= '0;
            out_ins1  <= '0;
            out_ins2  <= '0;
        end else if (do_load) begin
            out_aluop <= in_aluop;
            out_add   <= in_add;
            out_dr1   <= in_dr1;
            out_dr2   <= in_dr2;
            out_signe <= in_signe;
            out_jaddr <= in_jaddr;
            out_ins1  <= in_ins1;
            out_ins2  <= in_ins2;
        end
    end

`ifdef IDEX_PERF_EN
    logic stall_inc;
    logic bubble_inc;

    // Stalls count only when a real instruction is being held.
    assign stall_inc  = in_stall && !in_flush && out_valid;
    assign bubble_inc = in_flush || (do_load && !in_valid);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (in_cnt_clr),
        .count (out_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .clr   (in_cnt_clr),
        .count (out_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Directed bench for idex_pipe_stage; counter checks apply when IDEX_PERF_EN is defined.
module tb_idex_pipe_stage;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_stall, in_flush;
    logic [7:0]         in_ctrl;
    logic [ALUOP_W-1:0] in_aluop;
    logic [DATA_W-1:0]  in_add, in_dr1, in_dr2, in_signe, in_jaddr;
    logic [REG_W-1:0]   in_ins1, in_ins2;
    logic               out_valid;
    logic [7:0]         out_ctrl;
    logic [ALUOP_W-1:0] out_aluop;
    logic [DATA_W-1:0]  out_add, out_dr1, out_dr2, out_signe, out_jaddr;
    logic [REG_W-1:0]   out_ins1, out_ins2;
`ifdef IDEX_PERF_EN
    logic               in_cnt_clr;
    logic [CNT_W-1:0]   out_stall_cnt, out_bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    idex_pipe_stage #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .ALUOP_W(ALUOP_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_stall  (in_stall),
        .in_flush  (in_flush),
        .in_ctrl   (in_ctrl),
        .in_aluop  (in_aluop),
        .in_add    (in_add),
        .in_dr1    (in_dr1),
        .in_dr2    (in_dr2),
        .in_signe  (in_signe),
        .in_jaddr  (in_jaddr),
        .in_ins1   (in_ins1),
        .in_ins2   (in_ins2),
        .out_valid (out_valid),
        .out_ctrl  (out_ctrl),
        .out_aluop (out_aluop),
        .out_add   (out_add),
        .out_dr1   (out_dr1),
        .out_dr2   (out_dr2),
        .out_signe (out_signe),
        .out_jaddr (out_jaddr),
        .out_ins1  (out_ins1),
        .out_ins2  (out_ins2)
`ifdef IDEX_PERF_EN
        ,
        .in_cnt_clr    (in_cnt_clr),
        .out_stall_cnt (out_stall_cnt),
        .out_bubble_cnt(out_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [DATA_W-1:0] d1,
                         input logic [REG_W-1:0] r2, input logic [ALUOP_W-1:0] op);
        in_valid = v;
        in_ctrl  = c;
        in_dr1   = d1;
        in_ins2  = r2;
        in_aluop = op;
        in_add   = d1 ^ 32'h0000_0004;
        in_dr2   = ~d1;
        in_signe = d1 + 32'd1;
        in_jaddr = d1 - 32'd1;
        in_ins1  = r2 + 5'd1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_stall = 1'b0;
        in_flush = 1'b0;
`ifdef IDEX_PERF_EN
        in_cnt_clr = 1'b0;
`endif
        drive(1'b0, 8'h00, 32'h0, 5'd0, 3'd0);
        step();
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ctrl", 64'(out_ctrl), 64'h00);
        rst_n = 1'b1;

        // Basic load.
        drive(1'b1, 8'hA5, 32'hDEADBEEF, 5'd7, 3'd5);
        step();
        check("load_valid", 64'(out_valid), 64'd1);
        check("load_ctrl", 64'(out_ctrl), 64'hA5);
        check("load_dr1", 64'(out_dr1), 64'hDEADBEEF);
        check("load_dr2", 64'(out_dr2), 64'h21524110);
        check("load_ins2", 64'(out_ins2), 64'd7);
        check("load_aluop", 64'(out_aluop), 64'd5);
        check("load_jaddr", 64'(out_jaddr), 64'hDEADBEEE);

        // Stall three edges with different inputs present.
        drive(1'b1, 8'h5A, 32'h12345678, 5'd9, 3'd2);
        in_stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("stall_ctrl", 64'(out_ctrl), 64'hA5);
        check("stall_dr1", 64'(out_dr1), 64'hDEADBEEF);
        check("stall_valid", 64'(out_valid), 64'd1);
`ifdef IDEX_PERF_EN
        check("stall_cnt3", 64'(out_stall_cnt), 64'd3);
        check("bubble_cnt0", 64'(out_bubble_cnt), 64'd0);
`endif

        // Flush together with stall produces a bubble.
        in_flush = 1'b1;
        step();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(out_ctrl), 64'h00);
        check("flush_dr1", 64'(out_dr1), 64'hDEADBEEF);
`ifdef IDEX_PERF_EN
        check("flush_bubble", 64'(out_bubble_cnt), 64'd1);
        check("flush_stall", 64'(out_stall_cnt), 64'd3);
`endif

        // Load of an invalid slot: ctrl gated to zero, data still captured.
        in_flush = 1'b0;
        in_stall = 1'b0;
        drive(1'b0, 8'hFF, 32'h11112222, 5'd3, 3'd1);
        step();
        check("inv_valid", 64'(out_valid), 64'd0);
        check("inv_ctrl", 64'(out_ctrl), 64'h00);
        check("inv_dr1", 64'(out_dr1), 64'h11112222);
`ifdef IDEX_PERF_EN
        check("inv_bubble", 64'(out_bubble_cnt), 64'd2);
`endif

        // Stall of an empty slot does not count as a stall.
        in_stall = 1'b1;
        step();
`ifdef IDEX_PERF_EN
        check("empty_stall", 64'(out_stall_cnt), 64'd3);
`endif
        check("empty_stall_ctrl", 64'(out_ctrl), 64'h00);

        // Saturation then clear-beats-increment.
        in_stall = 1'b0;
        drive(1'b1, 8'h3C, 32'hCAFEF00D, 5'd12, 3'd6);
        step();
        check("reload_ctrl", 64'(out_ctrl), 64'h3C);
        in_stall = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat_hold_dr1", 64'(out_dr1), 64'hCAFEF00D);
`ifdef IDEX_PERF_EN
        check("sat_stall", 64'(out_stall_cnt), 64'd15);
        in_cnt_clr = 1'b1;
        step();
        in_cnt_clr = 1'b0;
        check("clr_stall", 64'(out_stall_cnt), 64'd0);
        check("clr_bubble", 64'(out_bubble_cnt), 64'd0);
`endif

        // Asynchronous reset mid-stall with nonzero inputs.
        in_flush = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ctrl", 64'(out_ctrl), 64'h00);
        check("arst_dr1", 64'(out_dr1), 64'h0);
        check("arst_aluop", 64'(out_aluop), 64'd0);
        check("arst_ins1", 64'(out_ins1), 64'd0);
`ifdef IDEX_PERF_EN
        check("arst_stall", 64'(out_stall_cnt), 64'd0);
`endif
        step();
        check("arst_hold_valid", 64'(out_valid), 64'd0);
        check("arst_hold_dr1", 64'(out_dr1), 64'h0);

        // First edge after release follows normal priority: load.
        rst_n    = 1'b1;
        in_flush = 1'b0;
        in_stall = 1'b0;
        step();
        check("rel_valid", 64'(out_valid), 64'd1);
        check("rel_ctrl", 64'(out_ctrl), 64'h3C);
        check("rel_dr1", 64'(out_dr1), 64'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idex_pipe_stage.md
IDEX_PIPE_STAGE -- requirements
Module: idex_pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the PC+4, register-data, sign-extended and jump-address fields SHALL be DATA_W.
REQ-002 Parameter REG_W, default 5, width of each register-specifier field SHALL be REG_W.
REQ-003 Parameter ALUOP_W, default 3, width of the ALU-op field SHALL be ALUOP_W.
REQ-004 Parameter CNT_W, default 16, width of each performance counter SHALL be CNT_W.
REQ-005 Ports SHALL be:
clk  in  1  rising-edge clock, single clock domain.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  ID stage holds a valid instruction.
in_stall  in  1  hold current contents (hazard unit).
in_flush  in  1  insert bubble (branch/jump taken).
in_ctrl  in  8  control bundle {jump,regw,memreg,memw,memr,branch,alusrc,regdst}, MSB first.
in_aluop  in  ALUOP_W  ALU operation.
in_add, in_dr1, in_dr2, in_signe, in_jaddr  in  DATA_W each  PC+4, read data 1/2, sign-extended immediate, jump address.
in_ins1, in_ins2  in  REG_W each  rt, rd specifiers.
in_cnt_clr  in  1  synchronous counter clear (only with IDEX_PERF_EN).
out_valid  out  1  EX stage holds a valid instruction.
out_ctrl, out_aluop, out_add, out_dr1, out_dr2, out_signe, out_jaddr, out_ins1, out_ins2  out  as inputs  registered copies.
out_stall_cnt, out_bubble_cnt  out  CNT_W each  performance counters (only with IDEX_PERF_EN).

Function
REQ-006 All outputs SHALL be registered; load latency SHALL be exactly one clk cycle.
REQ-007 Per rising edge, priority SHALL be flush > stall > load.
REQ-008 Flush: out_valid SHALL become 0 and out_ctrl SHALL become 8'h00; data fields SHALL hold their previous values.
REQ-009 Stall without flush: every output register SHALL hold its value.
REQ-010 Load (no flush, no stall): out_valid SHALL take in_valid and all fields SHALL take their inputs, except that out_ctrl SHALL be 8'h00 when in_valid is 0.
REQ-011 Flush and stall asserted together SHALL produce a bubble per REQ-008 (flush wins).
REQ-012 out_ctrl SHALL never be nonzero while out_valid is 0.
REQ-013 Stall counter SHALL increment on each edge with in_stall=1 and in_flush=0 while out_valid=1.
REQ-014 Bubble counter SHALL increment on each edge where flush occurs, or where load occurs with in_valid=0.
REQ-015 Both counters SHALL saturate at 2^CNT_W-1 with no wrap-around.
REQ-016 in_cnt_clr SHALL zero both counters on the next edge and SHALL override any increment in that cycle.

Reset
REQ-017 rst_n low SHALL immediately, without clk, force out_valid=0, out_ctrl=0, out_aluop=0, all data and specifier outputs=0, and both counters=0.
REQ-018 Reset asserted mid-stall or mid-flush SHALL override them; the first edge after release SHALL follow REQ-007.

Configuration
REQ-019 With macro IDEX_PERF_EN defined, REQ-013..REQ-016 counters, in_cnt_clr and the counter outputs SHALL exist.
REQ-020 Without IDEX_PERF_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 Shared package idex_pkg SHALL hold the ctrl-bundle bit-index constants (CTRL_JUMP=7 .. CTRL_REGDST=0), CTRL_W=8, and the bubble value CTRL_NOP=8'h00.
REQ-022 One sub-module, sat_counter (CNT_W, inc, clr, rst_n), SHALL be instantiated twice for the counters.

Verification
REQ-023 Reset: drive rst_n=0 between edges with inputs nonzero -> all outputs 0 at once, and still 0 after next edge.
REQ-024 Load: in_valid=1, in_ctrl=8'hA5, in_dr1=32'hDEADBEEF -> one edge later out_valid=1, out_ctrl=8'hA5, out_dr1=32'hDEADBEEF.
REQ-025 Stall: after load, in_stall=1 for 3 edges with new inputs -> outputs unchanged, out_stall_cnt=3.
REQ-026 Flush plus stall: in_flush=1, in_stall=1 -> out_valid=0, out_ctrl=0, out_dr1 unchanged, out_bubble_cnt increments by 1.
REQ-027 Saturation: CNT_W=4, 20 stall cycles -> out_stall_cnt=15; in_cnt_clr=1 together with in_stall=1 -> 0.
REQ-028 Build without IDEX_PERF_EN, then rerun REQ-024 and REQ-026 -> identical pipeline outputs.
